// File: rtl/tl_ul_arb2.sv
`default_nettype none
// ============================================================================
// tl_ul_arb2 : two-master TileLink-UL arbiter, round-robin A with stall lock,
//              source-tagged D routing, per-master outstanding throttling.
// Revision   : 1.0
// ============================================================================
module tl_ul_arb2 #(
   parameter int SRC_W   = 2,
   parameter int SIZE_W  = 2,
   parameter int MAX_OUT = 4,
   parameter int AP_W    = 74 + SIZE_W,
   parameter int DP_W    = 39 + SIZE_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               m0_a_valid,
   output logic               m0_a_ready,
   input  logic [SRC_W-1:0]   m0_a_source,
   input  logic [AP_W-1:0]    m0_a_payload,
   input  logic               m1_a_valid,
   output logic               m1_a_ready,
   input  logic [SRC_W-1:0]   m1_a_source,
   input  logic [AP_W-1:0]    m1_a_payload,
   output logic               s_a_valid,
   input  logic               s_a_ready,
   output logic [SRC_W:0]     s_a_source,
   output logic [AP_W-1:0]    s_a_payload,
   input  logic               s_d_valid,
   output logic               s_d_ready,
   input  logic [SRC_W:0]     s_d_source,
   input  logic [DP_W-1:0]    s_d_payload,
   output logic               m0_d_valid,
   input  logic               m0_d_ready,
   output logic [SRC_W-1:0]   m0_d_source,
   output logic [DP_W-1:0]    m0_d_payload,
   output logic               m1_d_valid,
   input  logic               m1_d_ready,
   output logic [SRC_W-1:0]   m1_d_source,
   output logic [DP_W-1:0]    m1_d_payload,
   output logic               busy,
   output logic               err
);

   localparam int              CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

   logic             rr_q, rr_d;
   logic             lock_q, lock_d;
   logic             lock_id_q, lock_id_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic elig0, elig1, grant, elig_grant, a_fire;
   logic d_tgt, d_fire, inc0, inc1, dec0, dec1;

   always_comb begin
      elig0 = m0_a_valid && (cnt0_q < CNT_MAX);
      elig1 = m1_a_valid && (cnt1_q < CNT_MAX);

      // A stalled beat keeps its grant; otherwise rr names the preferred master
      if (lock_q)
         grant = lock_id_q;
      else if (!rr_q)
         grant = !elig0 && elig1;
      else
         grant = elig1 || !elig0;
      elig_grant = grant ? elig1 : elig0;

      s_a_valid   = reset_n && elig_grant;
      a_fire      = s_a_valid && s_a_ready;
      m0_a_ready  = reset_n && s_a_ready && !grant && elig0;
      m1_a_ready  = reset_n && s_a_ready && grant && elig1;
      s_a_source  = grant ? {1'b1, m1_a_source} : {1'b0, m0_a_source};
      s_a_payload = grant ? m1_a_payload : m0_a_payload;

      d_tgt        = s_d_source[SRC_W];
      m0_d_valid   = reset_n && s_d_valid && !d_tgt;
      m1_d_valid   = reset_n && s_d_valid && d_tgt;
      s_d_ready    = reset_n && (d_tgt ? m1_d_ready : m0_d_ready);
      d_fire       = s_d_valid && s_d_ready;
      m0_d_source  = s_d_source[SRC_W-1:0];
      m1_d_source  = s_d_source[SRC_W-1:0];
      m0_d_payload = s_d_payload;
      m1_d_payload = s_d_payload;

      inc0 = a_fire && !grant;
      inc1 = a_fire && grant;
      dec0 = d_fire && !d_tgt;
      dec1 = d_fire && d_tgt;

      rr_d      = a_fire ? ~grant : rr_q;
      lock_id_d = lock_id_q;
      if (a_fire) begin
         lock_d = 1'b0;
      end else if (s_a_valid) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end else begin
         // also releases the lock if the locked master withdrew its request
         lock_d = 1'b0;
      end

      err_d = err_q || (dec0 && (cnt0_q == '0)) || (dec1 && (cnt1_q == '0));

      cnt0_d = cnt0_q;
      if (inc0 && !dec0)
         cnt0_d = cnt0_q + 1'b1;
      else if (dec0 && !inc0 && (cnt0_q != '0))
         cnt0_d = cnt0_q - 1'b1;

      cnt1_d = cnt1_q;
      if (inc1 && !dec1)
         cnt1_d = cnt1_q + 1'b1;
      else if (dec1 && !inc1 && (cnt1_q != '0))
         cnt1_d = cnt1_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rr_q      <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         err_q     <= 1'b0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         err_q     <= err_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

   assign busy = (cnt0_q != '0) || (cnt1_q != '0);
   assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_arb2.sv
`default_nettype none
// ============================================================================
// tb_tl_ul_arb2 : randomized scoreboard bench for tl_ul_arb2.
// Revision      : 1.0
// ============================================================================
module tb_tl_ul_arb2;

   localparam int SRC_W   = 2;
   localparam int SIZE_W  = 2;
   localparam int MAX_OUT = 4;
   localparam int AP_W    = 74 + SIZE_W;
   localparam int DP_W    = 39 + SIZE_W;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             m0_a_valid, m1_a_valid, m0_a_ready, m1_a_ready;
   logic [SRC_W-1:0] m0_a_source, m1_a_source;
   logic [AP_W-1:0]  m0_a_payload, m1_a_payload;
   logic             s_a_valid, s_a_ready;
   logic [SRC_W:0]   s_a_source;
   logic [AP_W-1:0]  s_a_payload;
   logic             s_d_valid, s_d_ready;
   logic [SRC_W:0]   s_d_source;
   logic [DP_W-1:0]  s_d_payload;
   logic             m0_d_valid, m1_d_valid, m0_d_ready, m1_d_ready;
   logic [SRC_W-1:0] m0_d_source, m1_d_source;
   logic [DP_W-1:0]  m0_d_payload, m1_d_payload;
   logic             busy, err;

   tl_ul_arb2 #(.SRC_W(SRC_W), .SIZE_W(SIZE_W), .MAX_OUT(MAX_OUT)) dut (
      .clock(clk), .reset_n(reset_n),
      .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
      .m0_a_source(m0_a_source), .m0_a_payload(m0_a_payload),
      .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
      .m1_a_source(m1_a_source), .m1_a_payload(m1_a_payload),
      .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
      .s_a_source(s_a_source), .s_a_payload(s_a_payload),
      .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
      .s_d_source(s_d_source), .s_d_payload(s_d_payload),
      .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
      .m0_d_source(m0_d_source), .m0_d_payload(m0_d_payload),
      .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
      .m1_d_source(m1_d_source), .m1_d_payload(m1_d_payload),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               rst;
      bit               sav, r0, r1, d0v, d1v, sdr, busy, err;
      logic [SRC_W:0]   sas;
      logic [AP_W-1:0]  sap;
   } sig_t;

   sig_t                      exp_sig[$];
   logic [SRC_W+AP_W:0]       exp_a[$];
   logic [SRC_W+DP_W:0]       exp_d[$];

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endfunction

   // Reference model: masters, slave response queue and arbiter behaviour
   bit               h_v[2];
   logic [SRC_W-1:0] h_src[2];
   logic [AP_W-1:0]  h_pay[2];
   logic [SRC_W:0]   dq[$];
   bit               d_act;
   logic [SRC_W:0]   d_src;
   logic [DP_W-1:0]  d_pay;
   int               m_prio, m_stall, m_cnt[2];
   bit               m_err;
   int               p_req, p_rdy, p_dvld, p_drdy;
   bit               no_new, inj, inj_rdy;

   function automatic logic [AP_W-1:0] rnd_ap();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[AP_W-1:0];
   endfunction

   function automatic logic [DP_W-1:0] rnd_dp();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DP_W-1:0];
   endfunction

   task automatic cycle(input bit rst);
      sig_t e;
      int   win;
      bit   el0, el1, afire, dfire, t, wb;
      @(posedge clk);
      #1;
      reset_n = !rst;
      for (int i = 0; i < 2; i++) begin
         if (!h_v[i] && (rst || (!no_new && $urandom_range(99) < p_req))) begin
            h_v[i]   = 1'b1;
            h_src[i] = SRC_W'($urandom());
            h_pay[i] = rnd_ap();
         end
      end
      m0_a_valid = h_v[0]; m0_a_source = h_src[0]; m0_a_payload = h_pay[0];
      m1_a_valid = h_v[1]; m1_a_source = h_src[1]; m1_a_payload = h_pay[1];
      s_a_ready  = rst || ($urandom_range(99) < p_rdy);
      m0_d_ready = rst || ($urandom_range(99) < p_drdy);
      m1_d_ready = rst || ($urandom_range(99) < p_drdy);
      if (rst) begin
         s_d_valid = 1'b1; s_d_source = (SRC_W+1)'($urandom()); s_d_payload = rnd_dp();
      end else if (inj) begin
         s_d_valid = 1'b1; s_d_source = 3'b110; s_d_payload = rnd_dp();
         m1_d_ready = inj_rdy;
      end else begin
         if (!d_act && dq.size() > 0 && $urandom_range(99) < p_dvld) begin
            d_act = 1'b1; d_src = dq[0]; d_pay = rnd_dp();
         end
         s_d_valid = d_act; s_d_source = d_src; s_d_payload = d_pay;
      end

      e = '{default: '0};
      e.rst = rst;
      if (rst) begin
         m_prio = 0; m_stall = -1; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 1'b0;
         exp_sig.push_back(e);
      end else begin
         win = -1;
         if (m_stall >= 0) begin
            if (h_v[m_stall]) win = m_stall;
         end else begin
            el0 = h_v[0] && m_cnt[0] < MAX_OUT;
            el1 = h_v[1] && m_cnt[1] < MAX_OUT;
            if (el0 && el1) win = m_prio;
            else if (el0)   win = 0;
            else if (el1)   win = 1;
         end
         afire = (win >= 0) && s_a_ready;
         e.sav = (win >= 0);
         if (win >= 0) begin
            wb    = (win == 1);
            e.sas = {wb, h_src[win]};
            e.sap = h_pay[win];
         end
         e.r0  = afire && win == 0;
         e.r1  = afire && win == 1;
         t     = s_d_source[SRC_W];
         e.d0v = s_d_valid && !t;
         e.d1v = s_d_valid && t;
         e.sdr = t ? m1_d_ready : m0_d_ready;
         dfire = s_d_valid && e.sdr;
         e.busy = (m_cnt[0] != 0) || (m_cnt[1] != 0);
         e.err  = m_err;
         exp_sig.push_back(e);
         if (afire) exp_a.push_back({e.sas, e.sap});
         if (dfire) exp_d.push_back({t, s_d_source[SRC_W-1:0], s_d_payload});

         for (int i = 0; i < 2; i++) begin
            bit inc, dec;
            inc = afire && win == i;
            dec = dfire && (t == (i == 1));
            if (dec && m_cnt[i] == 0) m_err = 1'b1;
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
         end
         if (dfire && !inj) begin
            void'(dq.pop_front());
            d_act = 1'b0;
         end
         if (afire) begin
            m_prio = 1 - win;
            h_v[win] = 1'b0;
            dq.push_back(e.sas);
         end
         m_stall = ((win >= 0) && !afire) ? win : -1;
      end
      mon_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_sig.size() == 0) begin
            chk("sig_queue", 1, 0);
         end else begin
            sig_t e;
            e = exp_sig.pop_front();
            chk("handshake", {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready},
                {e.sav, e.r0, e.r1, e.d0v, e.d1v, e.sdr});
            if (!e.rst) chk("busy_err", {busy, err}, {e.busy, e.err});
            if (e.sav) chk("a_src_pay", {s_a_source, s_a_payload}, {e.sas, e.sap});
         end
         if (s_a_valid && s_a_ready) begin
            if (exp_a.size() == 0) chk("a_fire_unexpected", 1, 0);
            else chk("a_fire", {s_a_source, s_a_payload}, exp_a.pop_front());
         end
         if (s_d_valid && s_d_ready) begin
            if (exp_d.size() == 0) chk("d_fire_unexpected", 1, 0);
            else if (m1_d_valid) chk("d_fire", {1'b1, m1_d_source, m1_d_payload}, exp_d.pop_front());
            else chk("d_fire", {1'b0, m0_d_source, m0_d_payload}, exp_d.pop_front());
         end
      end
   end

   task automatic run(input int n, input int rq, input int rd, input int dv, input int dr);
      p_req = rq; p_rdy = rd; p_dvld = dv; p_drdy = dr;
      for (int k = 0; k < n; k++) cycle(1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      m0_a_valid = 0; m1_a_valid = 0; s_a_ready = 0; s_d_valid = 0;
      m0_d_ready = 0; m1_d_ready = 0;
      m0_a_source = '0; m1_a_source = '0; m0_a_payload = '0; m1_a_payload = '0;
      s_d_source = '0; s_d_payload = '0;
      h_v[0] = 0; h_v[1] = 0; d_act = 0; d_src = '0; d_pay = '0;
      no_new = 0; inj = 0; inj_rdy = 0;
      m_prio = 0; m_stall = -1; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
      p_req = 0; p_rdy = 0; p_dvld = 0; p_drdy = 0;

      for (int k = 0; k < 3; k++) cycle(1'b1);
      run(2, 0, 100, 0, 100);
      run(24, 100, 100, 0, 100);
      run(600, 80, 40, 50, 70);
      run(400, 90, 20, 30, 60);
      for (int b = 0; b < 20; b++)
         run(50, $urandom_range(100), $urandom_range(10, 100),
             $urandom_range(10, 100), $urandom_range(10, 100));

      no_new = 1'b1;
      begin
         int guard = 0;
         p_rdy = 100; p_dvld = 100; p_drdy = 100;
         while ((h_v[0] || h_v[1] || dq.size() != 0 || d_act) && guard < 300) begin
            cycle(1'b0);
            guard++;
         end
         if (guard >= 300) chk("drain_timeout", 1, 0);
      end

      inj = 1'b1; inj_rdy = 1'b0;
      cycle(1'b0); cycle(1'b0);
      inj_rdy = 1'b1;
      cycle(1'b0);
      inj = 1'b0;
      no_new = 1'b0;
      run(40, 70, 60, 50, 70);

      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      chk("leftover_a", exp_a.size(), 0);
      chk("leftover_d", exp_d.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
